// File: rtl/rename_map_ckpt_if.sv
// Rename unit bundle: decode request, renamed response, and the
// writeback / commit / branch-recovery side channels.
interface rename_map_ckpt_if #(
   parameter int NUM_ARCH = 32,
   parameter int NUM_PHYS = 64,
   parameter int NUM_CKPT = 4
);
   localparam int ARCH_W = $clog2(NUM_ARCH);
   localparam int PHYS_W = $clog2(NUM_PHYS);
   localparam int CKPT_W = $clog2(NUM_CKPT);

   logic              in_valid;
   logic              in_ready;
   logic [ARCH_W-1:0] in_rs;
   logic [ARCH_W-1:0] in_rt;
   logic [ARCH_W-1:0] in_rw;
   logic              in_uses_rw;
   logic              in_is_branch;

   logic              out_valid;
   logic [PHYS_W-1:0] out_rs_phys;
   logic [PHYS_W-1:0] out_rt_phys;
   logic [PHYS_W-1:0] out_rw_phys;
   logic [PHYS_W-1:0] out_old_phys;
   logic              out_rs_ready;
   logic              out_rt_ready;
   logic [CKPT_W-1:0] out_ckpt;

   logic              wb_valid;
   logic [PHYS_W-1:0] wb_phys;
   logic              commit_valid;
   logic [PHYS_W-1:0] commit_old_phys;
   logic              resolve_valid;
   logic              flush_valid;
   logic [CKPT_W-1:0] flush_ckpt;
   logic [PHYS_W:0]   fl_count;

   modport master (
      output in_valid, in_rs, in_rt, in_rw, in_uses_rw, in_is_branch,
      output wb_valid, wb_phys, commit_valid, commit_old_phys,
      output resolve_valid, flush_valid, flush_ckpt,
      input  in_ready, out_valid, out_rs_phys, out_rt_phys, out_rw_phys,
      input  out_old_phys, out_rs_ready, out_rt_ready, out_ckpt, fl_count
   );

   modport slave (
      input  in_valid, in_rs, in_rt, in_rw, in_uses_rw, in_is_branch,
      input  wb_valid, wb_phys, commit_valid, commit_old_phys,
      input  resolve_valid, flush_valid, flush_ckpt,
      output in_ready, out_valid, out_rs_phys, out_rt_phys, out_rw_phys,
      output out_old_phys, out_rs_ready, out_rt_ready, out_ckpt, fl_count
   );
endinterface

// File: rtl/rename_map_ckpt.sv
// Single-issue register rename: RMT, circular free list, busy table and branch checkpoints
// for single-cycle mispredict recovery. Define RENAME_ZERO_REG_EN to hard-wire r0 to p0.
module rename_map_ckpt #(
   parameter int NUM_ARCH = 32,
   parameter int NUM_PHYS = 64,
   parameter int NUM_CKPT = 4
) (
   input logic              clk,
   input logic              rst_n,
   rename_map_ckpt_if.slave bus
);
   localparam int PHYS_W  = $clog2(NUM_PHYS);
   localparam int CKPT_W  = $clog2(NUM_CKPT);
   localparam int FL_D    = NUM_PHYS - NUM_ARCH;
   localparam int FL_IW   = $clog2(FL_D);
   localparam int PTR_MOD = 2 * FL_D;

   typedef logic [PHYS_W-1:0] tag_t;
   typedef logic [PHYS_W:0]   ptr_t;  // runs over two laps so full and empty differ
   typedef logic [CKPT_W-1:0] cid_t;
   typedef logic [CKPT_W:0]   cnt_t;

   function automatic ptr_t ptr_inc(input ptr_t p);
      return (p == ptr_t'(PTR_MOD - 1)) ? '0 : p + ptr_t'(1);
   endfunction

   function automatic logic [FL_IW-1:0] ptr_idx(input ptr_t p);
      ptr_t r;
      r = (p >= ptr_t'(FL_D)) ? p - ptr_t'(FL_D) : p;
      return FL_IW'(r);
   endfunction

   tag_t                rmt_q [NUM_ARCH];
   tag_t                rmt_d [NUM_ARCH];
   tag_t                fl_q [FL_D];
   tag_t                fl_d [FL_D];
   ptr_t                fl_head_q, fl_head_d, fl_tail_q, fl_tail_d;
   logic [NUM_PHYS-1:0] busy_q, busy_d;
   tag_t                ckpt_rmt_q [NUM_CKPT][NUM_ARCH];
   tag_t                ckpt_rmt_d [NUM_CKPT][NUM_ARCH];
   ptr_t                ckpt_fl_head_q [NUM_CKPT];
   ptr_t                ckpt_fl_head_d [NUM_CKPT];
   cid_t                ckpt_head_q, ckpt_head_d, ckpt_tail_q, ckpt_tail_d;
   cnt_t                ckpt_used_q, ckpt_used_d;

   logic                out_valid_q, out_valid_d;
   tag_t                out_rs_phys_q, out_rs_phys_d, out_rt_phys_q, out_rt_phys_d;
   tag_t                out_rw_phys_q, out_rw_phys_d, out_old_phys_q, out_old_phys_d;
   logic                out_rs_ready_q, out_rs_ready_d, out_rt_ready_q, out_rt_ready_d;
   cid_t                out_ckpt_q, out_ckpt_d;

   logic                in_ready, fire, alloc, resolve_ok;
   ptr_t                fl_count;
   tag_t                new_tag, rs_phys, rt_phys;
   cid_t                flush_diff;
   cnt_t                used_after_resolve;

   always_comb begin
      int cnt;
      cnt = int'(fl_tail_q) - int'(fl_head_q);
      if (cnt < 0) cnt = cnt + PTR_MOD;
      fl_count = ptr_t'(cnt);

      in_ready = !bus.flush_valid
               && (!bus.in_uses_rw || fl_count != '0)
               && (!bus.in_is_branch || ckpt_used_q != cnt_t'(NUM_CKPT));
      fire = bus.in_valid && in_ready;
`ifdef RENAME_ZERO_REG_EN
      alloc = fire && bus.in_uses_rw && (bus.in_rw != '0);
`else
      alloc = fire && bus.in_uses_rw;
`endif
      new_tag            = fl_q[ptr_idx(fl_head_q)];
      rs_phys            = rmt_q[bus.in_rs];
      rt_phys            = rmt_q[bus.in_rt];
      resolve_ok         = bus.resolve_valid && (ckpt_used_q != '0);
      used_after_resolve = ckpt_used_q - cnt_t'(resolve_ok);
      flush_diff         = '0;

      rmt_d          = rmt_q;
      fl_d           = fl_q;
      fl_head_d      = fl_head_q;
      fl_tail_d      = fl_tail_q;
      busy_d         = busy_q;
      ckpt_rmt_d     = ckpt_rmt_q;
      ckpt_fl_head_d = ckpt_fl_head_q;
      ckpt_head_d    = ckpt_head_q;
      ckpt_tail_d    = ckpt_tail_q;
      ckpt_used_d    = used_after_resolve;

      out_valid_d    = fire;
      out_rs_phys_d  = out_rs_phys_q;
      out_rt_phys_d  = out_rt_phys_q;
      out_rw_phys_d  = out_rw_phys_q;
      out_old_phys_d = out_old_phys_q;
      out_rs_ready_d = out_rs_ready_q;
      out_rt_ready_d = out_rt_ready_q;
      out_ckpt_d     = out_ckpt_q;

      // Writeback clears first so a same-cycle reallocation of that tag wins.
      if (bus.wb_valid) busy_d[bus.wb_phys] = 1'b0;
      if (alloc) begin
         rmt_d[bus.in_rw] = new_tag;
         busy_d[new_tag]  = 1'b1;
         fl_head_d        = ptr_inc(fl_head_q);
      end
      if (bus.commit_valid) begin
         fl_d[ptr_idx(fl_tail_q)] = bus.commit_old_phys;
         fl_tail_d                = ptr_inc(fl_tail_q);
      end
      if (resolve_ok) ckpt_head_d = ckpt_head_q + cid_t'(1);

      if (fire && bus.in_is_branch) begin
         ckpt_rmt_d[ckpt_tail_q]     = rmt_d;
         ckpt_fl_head_d[ckpt_tail_q] = fl_head_d;
         ckpt_tail_d                 = ckpt_tail_q + cid_t'(1);
         ckpt_used_d                 = used_after_resolve + cnt_t'(1);
      end

      // Rename is blocked on flush, so the restore never collides with a fire.
      if (bus.flush_valid) begin
         rmt_d       = ckpt_rmt_q[bus.flush_ckpt];
         fl_head_d   = ckpt_fl_head_q[bus.flush_ckpt];
         ckpt_tail_d = bus.flush_ckpt + cid_t'(1);
         flush_diff  = ckpt_tail_d - ckpt_head_d;
         ckpt_used_d = (flush_diff == '0 && used_after_resolve != '0)
                     ? cnt_t'(NUM_CKPT) : cnt_t'(flush_diff);
      end
`ifdef RENAME_ZERO_REG_EN
      busy_d[0] = 1'b0;
`endif

      if (fire) begin
         out_rs_phys_d  = rs_phys;
         out_rt_phys_d  = rt_phys;
         out_rs_ready_d = !busy_q[rs_phys] || (bus.wb_valid && bus.wb_phys == rs_phys);
         out_rt_ready_d = !busy_q[rt_phys] || (bus.wb_valid && bus.wb_phys == rt_phys);
         out_rw_phys_d  = alloc ? new_tag : '0;
         out_old_phys_d = alloc ? rmt_q[bus.in_rw] : '0;
         out_ckpt_d     = bus.in_is_branch ? ckpt_tail_q : '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_ARCH; i++) rmt_q[i] <= tag_t'(i);
         for (int i = 0; i < FL_D; i++) fl_q[i] <= tag_t'(NUM_ARCH + i);
         for (int c = 0; c < NUM_CKPT; c++) begin
            ckpt_fl_head_q[c] <= '0;
            for (int a = 0; a < NUM_ARCH; a++) ckpt_rmt_q[c][a] <= '0;
         end
         fl_head_q      <= '0;
         fl_tail_q      <= ptr_t'(FL_D);
         busy_q         <= '0;
         ckpt_head_q    <= '0;
         ckpt_tail_q    <= '0;
         ckpt_used_q    <= '0;
         out_valid_q    <= 1'b0;
         out_rs_phys_q  <= '0;
         out_rt_phys_q  <= '0;
         out_rw_phys_q  <= '0;
         out_old_phys_q <= '0;
         out_rs_ready_q <= 1'b0;
         out_rt_ready_q <= 1'b0;
         out_ckpt_q     <= '0;
      end else begin
         rmt_q          <= rmt_d;
         fl_q           <= fl_d;
         fl_head_q      <= fl_head_d;
         fl_tail_q      <= fl_tail_d;
         busy_q         <= busy_d;
         ckpt_rmt_q     <= ckpt_rmt_d;
         ckpt_fl_head_q <= ckpt_fl_head_d;
         ckpt_head_q    <= ckpt_head_d;
         ckpt_tail_q    <= ckpt_tail_d;
         ckpt_used_q    <= ckpt_used_d;
         out_valid_q    <= out_valid_d;
         out_rs_phys_q  <= out_rs_phys_d;
         out_rt_phys_q  <= out_rt_phys_d;
         out_rw_phys_q  <= out_rw_phys_d;
         out_old_phys_q <= out_old_phys_d;
         out_rs_ready_q <= out_rs_ready_d;
         out_rt_ready_q <= out_rt_ready_d;
         out_ckpt_q     <= out_ckpt_d;
      end
   end

   assign bus.in_ready     = in_ready;
   assign bus.fl_count     = fl_count;
   assign bus.out_valid    = out_valid_q;
   assign bus.out_rs_phys  = out_rs_phys_q;
   assign bus.out_rt_phys  = out_rt_phys_q;
   assign bus.out_rw_phys  = out_rw_phys_q;
   assign bus.out_old_phys = out_old_phys_q;
   assign bus.out_rs_ready = out_rs_ready_q;
   assign bus.out_rt_ready = out_rt_ready_q;
   assign bus.out_ckpt     = out_ckpt_q;
endmodule

// File: tb/tb_rename_map_ckpt.sv
// Bench for rename_map_ckpt: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_rename_map_ckpt;
   localparam int NA = 32;
   localparam int NP = 64;
   localparam int NC = 4;
   localparam int AW = $clog2(NA);
   localparam int PW = $clog2(NP);
   localparam int CW = $clog2(NC);

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   rename_map_ckpt_if #(.NUM_ARCH(NA), .NUM_PHYS(NP), .NUM_CKPT(NC)) bus ();
   rename_map_ckpt #(.NUM_ARCH(NA), .NUM_PHYS(NP), .NUM_CKPT(NC)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Reference model: map array, free list as a queue, pop history for recovery,
   // held checkpoints as a queue of ids.
   int m_rmt [NA];
   int m_fl [$];
   int m_hist [$];
   bit m_busy [NP];
   int ck_rmt [NC][NA];
   int ck_np [NC];
   int m_ckq [$];
   int m_nid;
   bit e_v, e_rsr, e_rtr;
   int e_rs, e_rt, e_rw, e_old, e_ck;

   task automatic m_reset();
      for (int i = 0; i < NA; i++) m_rmt[i] = i;
      m_fl.delete();
      for (int i = NA; i < NP; i++) m_fl.push_back(i);
      m_hist.delete();
      for (int i = 0; i < NP; i++) m_busy[i] = 1'b0;
      m_ckq.delete();
      m_nid = 0;
      e_v = 0; e_rsr = 0; e_rtr = 0;
      e_rs = 0; e_rt = 0; e_rw = 0; e_old = 0; e_ck = 0;
   endtask

   task automatic m_step(input bit rdy);
      bit fire, alloc;
      int t, p, id;
      fire = bus.in_valid && rdy;
      alloc = fire && bus.in_uses_rw;
`ifdef RENAME_ZERO_REG_EN
      if (bus.in_rw == 0) alloc = 0;
`endif
      e_v = fire;
      if (fire) begin
         e_rs  = m_rmt[bus.in_rs];
         e_rt  = m_rmt[bus.in_rt];
         e_rsr = !m_busy[e_rs] || (bus.wb_valid && int'(bus.wb_phys) == e_rs);
         e_rtr = !m_busy[e_rt] || (bus.wb_valid && int'(bus.wb_phys) == e_rt);
         e_rw = 0; e_old = 0; e_ck = 0;
      end
      if (bus.wb_valid) m_busy[bus.wb_phys] = 1'b0;
      if (alloc) begin
         t = m_fl.pop_front();
         m_hist.push_back(t);
         e_rw = t;
         e_old = m_rmt[bus.in_rw];
         m_rmt[bus.in_rw] = t;
         m_busy[t] = 1'b1;
      end
      if (fire && bus.in_is_branch) begin
         e_ck = m_nid;
         ck_rmt[m_nid] = m_rmt;
         ck_np[m_nid] = m_hist.size();
         m_ckq.push_back(m_nid);
         m_nid = (m_nid + 1) % NC;
      end
      if (bus.resolve_valid && m_ckq.size() != 0) void'(m_ckq.pop_front());
      if (bus.flush_valid) begin
         id = int'(bus.flush_ckpt);
         p = -1;
         foreach (m_ckq[i]) if (m_ckq[i] == id) p = i;
         while (m_ckq.size() > p + 1) void'(m_ckq.pop_back());
         m_rmt = ck_rmt[id];
         while (m_hist.size() > ck_np[id]) m_fl.push_front(m_hist.pop_back());
         m_nid = (id + 1) % NC;
      end
      if (bus.commit_valid) m_fl.push_back(int'(bus.commit_old_phys));
   endtask

   // Inputs change at posedge+1; the model samples and advances at the negedge.
   always @(negedge clk) begin
      bit rdy;
      if (!rst_n) m_reset();
      else begin
         chk("out_valid", 32'(bus.out_valid), 32'(e_v));
         if (e_v) begin
            chk("out_rs_phys", 32'(bus.out_rs_phys), e_rs);
            chk("out_rt_phys", 32'(bus.out_rt_phys), e_rt);
            chk("out_rw_phys", 32'(bus.out_rw_phys), e_rw);
            chk("out_old_phys", 32'(bus.out_old_phys), e_old);
            chk("out_rs_ready", 32'(bus.out_rs_ready), 32'(e_rsr));
            chk("out_rt_ready", 32'(bus.out_rt_ready), 32'(e_rtr));
            if (bus.out_valid && e_ck != 0) chk("out_ckpt", 32'(bus.out_ckpt), e_ck);
         end
         rdy = !bus.flush_valid && (!bus.in_uses_rw || m_fl.size() != 0)
             && (!bus.in_is_branch || m_ckq.size() != NC);
         chk("in_ready", 32'(bus.in_ready), 32'(rdy));
         chk("fl_count", 32'(bus.fl_count), m_fl.size());
         m_step(rdy);
      end
   end

   task automatic idle();
      bus.in_valid = 0; bus.in_rs = '0; bus.in_rt = '0; bus.in_rw = '0;
      bus.in_uses_rw = 0; bus.in_is_branch = 0;
      bus.wb_valid = 0; bus.wb_phys = '0;
      bus.commit_valid = 0; bus.commit_old_phys = '0;
      bus.resolve_valid = 0; bus.flush_valid = 0; bus.flush_ckpt = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ren(input int rs, input int rt, input int rw, input bit uses, input bit br);
      bus.in_valid = 1;
      bus.in_rs = AW'(rs); bus.in_rt = AW'(rt); bus.in_rw = AW'(rw);
      bus.in_uses_rw = uses; bus.in_is_branch = br;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 0;
      #2;
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_fl_count", 32'(bus.fl_count), 32);
      chk("rst_out_rw_phys", 32'(bus.out_rw_phys), 0);
      tick();
      rst_n = 1;
   endtask

   initial begin
      idle();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_fl_count", 32'(bus.fl_count), 32);
      chk("rst_out_ckpt", 32'(bus.out_ckpt), 0);
      rst_n = 1;

      // Basic rename, rs == rw reads the old mapping
      ren(5, 3, 5, 1, 0); tick(); idle();
      chk("t1_rw_phys", 32'(bus.out_rw_phys), 32);
      chk("t1_old_phys", 32'(bus.out_old_phys), 5);
      chk("t1_rs_phys", 32'(bus.out_rs_phys), 5);
      chk("t1_rt_phys", 32'(bus.out_rt_phys), 3);
      chk("t1_rs_ready", 32'(bus.out_rs_ready), 1);
      chk("t1_rt_ready", 32'(bus.out_rt_ready), 1);
      chk("t1_fl_count", 32'(bus.fl_count), 31);
      tick();
      chk("t1_one_shot", 32'(bus.out_valid), 0);

      // Busy source, then writeback bypass in the same cycle
      do_reset();
      ren(0, 0, 1, 1, 0); tick();
      chk("t3_rw_phys", 32'(bus.out_rw_phys), 32);
      ren(1, 0, 0, 0, 0); tick();
      chk("t3_rs_phys", 32'(bus.out_rs_phys), 32);
      chk("t3_busy_not_ready", 32'(bus.out_rs_ready), 0);
      ren(1, 0, 0, 0, 0); bus.wb_valid = 1; bus.wb_phys = PW'(32); tick(); idle();
      chk("t3_bypass_ready", 32'(bus.out_rs_ready), 1);

      // Drain the free list, then stall writers but not non-writers
      do_reset();
      for (int i = 0; i < 32; i++) begin
         ren(0, 0, i, 1, 0); tick();
         chk("t2_fill_tag", 32'(bus.out_rw_phys), 32 + i);
      end
      ren(0, 0, 7, 1, 0); #2;
      chk("t2_full_in_ready", 32'(bus.in_ready), 0);
      tick();
      chk("t2_full_no_fire", 32'(bus.out_valid), 0);
      chk("t2_fl_empty", 32'(bus.fl_count), 0);
      ren(1, 2, 0, 0, 0); #2;
      chk("t2_nonwriter_ready", 32'(bus.in_ready), 1);
      tick();
      chk("t2_nonwriter_fires", 32'(bus.out_valid), 1);
      chk("t2_nonwriter_rs", 32'(bus.out_rs_phys), 33);
      idle(); bus.commit_valid = 1; bus.commit_old_phys = PW'(5); tick(); idle();
      chk("t2_commit_count", 32'(bus.fl_count), 1);
      ren(0, 0, 9, 1, 0); bus.commit_valid = 1; bus.commit_old_phys = PW'(3); tick(); idle();
      chk("t2_reuse_tag", 32'(bus.out_rw_phys), 5);
      chk("t2_pop_push_count", 32'(bus.fl_count), 1);

      // Checkpoint, speculative writers, flush (with a commit in the flush cycle)
      do_reset();
      ren(0, 0, 2, 1, 0); tick();
      ren(0, 0, 0, 0, 1); tick();
      chk("t4_ckpt_id", 32'(bus.out_ckpt), 0);
      ren(0, 0, 3, 1, 0); tick();
      chk("t4_spec_tag0", 32'(bus.out_rw_phys), 33);
      ren(0, 0, 4, 1, 0); tick();
      chk("t4_spec_tag1", 32'(bus.out_rw_phys), 34);
      ren(0, 0, 5, 1, 0);
      bus.flush_valid = 1; bus.flush_ckpt = CW'(0);
      bus.commit_valid = 1; bus.commit_old_phys = PW'(2);
      #2;
      chk("t4_flush_blocks", 32'(bus.in_ready), 0);
      tick(); idle();
      chk("t4_flush_no_out", 32'(bus.out_valid), 0);
      chk("t4_flush_count", 32'(bus.fl_count), 32);
      ren(3, 4, 6, 1, 0); tick();
      chk("t4_restored_rs", 32'(bus.out_rs_phys), 3);
      chk("t4_restored_rt", 32'(bus.out_rt_phys), 4);
      chk("t4_realloc_tag", 32'(bus.out_rw_phys), 33);
      ren(2, 0, 0, 0, 0); tick(); idle();
      chk("t4_kept_map", 32'(bus.out_rs_phys), 32);

      // Fill all checkpoints, stall, resolve, wrap to slot 0
      do_reset();
      for (int i = 0; i < NC; i++) begin
         ren(0, 0, 0, 0, 1); tick();
         chk("t5_ckpt_seq", 32'(bus.out_ckpt), i);
      end
      ren(0, 0, 0, 0, 1); #2;
      chk("t5_full_stall", 32'(bus.in_ready), 0);
      bus.resolve_valid = 1; tick(); bus.resolve_valid = 0;
      chk("t5_stalled_no_out", 32'(bus.out_valid), 0);
      tick();
      chk("t5_wrap_fires", 32'(bus.out_valid), 1);
      chk("t5_wrap_ckpt", 32'(bus.out_ckpt), 0);
      idle();

      // Resolve + flush together: held {1,2,3,0} -> {2,3}
      bus.resolve_valid = 1; bus.flush_valid = 1; bus.flush_ckpt = CW'(3); tick(); idle();
      ren(0, 0, 0, 0, 1); tick();
      chk("t6_after_flush_ckpt", 32'(bus.out_ckpt), 0);
      tick();
      chk("t6_next_ckpt", 32'(bus.out_ckpt), 1);
      #2;
      chk("t6_full_again", 32'(bus.in_ready), 0);
      idle(); bus.flush_valid = 1; bus.flush_ckpt = CW'(1); tick(); idle();
      ren(0, 0, 0, 0, 1); #2;
      chk("t6_youngest_flush_full", 32'(bus.in_ready), 0);
      tick(); idle();

      // Writer to r0
      do_reset();
      ren(0, 0, 0, 1, 0); tick(); idle();
`ifdef RENAME_ZERO_REG_EN
      chk("t7_r0_rw_phys", 32'(bus.out_rw_phys), 0);
      chk("t7_r0_fl_count", 32'(bus.fl_count), 32);
`else
      chk("t7_r0_rw_phys", 32'(bus.out_rw_phys), 32);
      chk("t7_r0_fl_count", 32'(bus.fl_count), 31);
`endif
      tick(); tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
